// File: rtl/freq_div_pkg.sv
// Shared definitions for the clock divider and its frequency detector:
// divide-ratio table, detector FSM states and default widths.
package freq_div_pkg;

    localparam int WIDTH_SEL_DEF    = 3;
    localparam int WIDTH_INSIDE_DEF = 32;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKED
    } fd_state_e;

    // Select code k divides by 2^(k+1).
    function automatic logic [31:0] sel_to_ratio(input int k);
        return 32'd1 << (k + 1);
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser followed by an edge flop; flags a rising edge of din
// for one clk cycle, two cycles after it is first sampled.
module edge_sync (
    input  logic clk,
    input  logic RST,
    input  logic din,
    output logic rise
);

    logic [2:0] sync_pipe;

    always_ff @(posedge clk) begin
        if (!RST) sync_pipe <= '0;
        else      sync_pipe <= {sync_pipe[1:0], din};
    end

    assign rise = sync_pipe[1] & ~sync_pipe[2];

endmodule

// File: rtl/freq_detector.sv
// Measures the period of a divided clock fin and recovers its select code.
// Optional FREQ_DETECTOR_TOL_EN: accept periods within +/-1 cycle of a ratio.
module freq_detector
    import freq_div_pkg::*;
#(
    parameter int width_sel    = WIDTH_SEL_DEF,
    parameter int width_inside = WIDTH_INSIDE_DEF,
    parameter int LOCK_CNT     = 2,
    parameter int TIMEOUT      = 512
) (
    input  logic                    clk,
    input  logic                    RST,
    input  logic                    fin,
    output logic [width_sel-1:0]    fsel_out,
    output logic                    locked,
    output logic                    per_pulse,
    output logic                    per_match,
    output logic [width_inside-1:0] period
);

    localparam int NUM_SEL = 1 << width_sel;
    localparam int HITS_W  = $clog2(LOCK_CNT + 1);
    localparam logic [width_inside-1:0] TO_VAL = width_inside'(TIMEOUT - 1);

    logic                    rise;
    logic [width_inside-1:0] cnt;
    logic [width_inside-1:0] meas;
    logic [NUM_SEL-1:0]      hit;
    logic                    match;
    logic [width_sel-1:0]    code;
    logic                    timeout;
    logic                    pulse;

    fd_state_e               state, state_nxt;
    logic [width_sel-1:0]    cand, cand_nxt, fsel_nxt;
    logic [HITS_W-1:0]       hits, hits_nxt;
    logic                    locked_nxt;

    edge_sync u_sync (
        .clk  (clk),
        .RST  (RST),
        .din  (fin),
        .rise (rise)
    );

    // Period ending at this rise; saturates with the counter.
    assign meas    = (&cnt) ? cnt : cnt + 1'b1;
    assign timeout = (cnt == TO_VAL);

    for (genvar k = 0; k < NUM_SEL; k++) begin : g_cmp
        localparam logic [width_inside-1:0] RATIO = width_inside'(sel_to_ratio(k));
`ifdef FREQ_DETECTOR_TOL_EN
        assign hit[k] = (meas >= RATIO - 1'b1) && (meas <= RATIO + 1'b1);
`else
        assign hit[k] = (meas == RATIO);
`endif
    end

    // Smallest matching code wins where tolerance windows overlap.
    always_comb begin
        match = 1'b0;
        code  = '0;
        for (int k = NUM_SEL - 1; k >= 0; k--) begin
            if (hit[k]) begin
                match = 1'b1;
                code  = width_sel'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        cand_nxt   = cand;
        hits_nxt   = hits;
        fsel_nxt   = fsel_out;
        locked_nxt = locked;
        pulse      = 1'b0;
        case (state)
            IDLE: begin
                hits_nxt = '0;
                if (rise) state_nxt = MEASURE;
            end
            MEASURE: begin
                if (rise) begin
                    pulse = 1'b1;
                    if (match && code == cand) begin
                        hits_nxt = hits + 1'b1;
                    end else begin
                        cand_nxt = code;
                        hits_nxt = HITS_W'(match);
                    end
                    if (hits_nxt == HITS_W'(LOCK_CNT)) begin
                        state_nxt  = LOCKED;
                        fsel_nxt   = cand_nxt;
                        locked_nxt = 1'b1;
                    end
                end else if (timeout) begin
                    state_nxt  = IDLE;
                    locked_nxt = 1'b0;
                end
            end
            LOCKED: begin
                if (rise) begin
                    pulse = 1'b1;
                    if (!(match && code == fsel_out)) begin
                        state_nxt  = MEASURE;
                        locked_nxt = 1'b0;
                        cand_nxt   = code;
                        hits_nxt   = HITS_W'(match);
                    end
                end else if (timeout) begin
                    state_nxt  = IDLE;
                    locked_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            cnt       <= '0;
            period    <= '0;
            per_pulse <= 1'b0;
            per_match <= 1'b0;
            locked    <= 1'b0;
            fsel_out  <= '0;
            cand      <= '0;
            hits      <= '0;
        end else begin
            cand      <= cand_nxt;
            hits      <= hits_nxt;
            fsel_out  <= fsel_nxt;
            locked    <= locked_nxt;
            per_pulse <= pulse;
            per_match <= pulse & match;
            if (state == IDLE || rise) cnt <= '0;
            else if (!(&cnt))          cnt <= cnt + 1'b1;
            if (pulse) period <= meas;
        end
    end

endmodule
